// File: rtl/ikaopll_acc_mixer.sv
// ikaopll_acc_mixer: per-frame signed mix of enabled DAC slots with volume scaling and saturation
module ikaopll_acc_mixer #(
  parameter int CYC_DLY   = 3,
  parameter int OUT_SHIFT = 1,
  parameter int STRB_LEN  = 8
) (
  input  logic        i_EMUCLK,
  input  logic        i_RST,
  input  logic        i_phi1_NCEN_n,
  input  logic        i_CYCLE_00,
  input  logic        i_INHIBIT_FDBK,
  input  logic        i_DAC_EN_MO,
  input  logic        i_DAC_EN_RO,
  input  logic        i_SND_SIGN,
  input  logic [7:0]  i_SND_MAG,
  input  logic [4:0]  i_MOVOL,
  input  logic [4:0]  i_ROVOL,
  output logic [15:0] o_ACC_SIGNED,
  output logic        o_ACC_SIGNED_STRB,
  output logic        o_ACC_CLIP
);
  logic signed [8:0]  s;
  logic signed [4:0]  vol;
  logic signed [13:0] prod;
  logic               prod_v;
  logic signed [17:0] acc, sum, r;
  logic signed [18:0] raw;
  logic signed [15:0] sat;
  logic [CYC_DLY-1:0] dly;
  logic [3:0]         cnt;
  logic               mk, first_frame, clip;

  assign s    = i_SND_SIGN ? {1'b1, ~i_SND_MAG} : {1'b0, i_SND_MAG};
  assign vol  = i_DAC_EN_RO ? i_ROVOL : i_MOVOL;
  assign mk   = dly[CYC_DLY-1];
  // one guard bit catches the 18-bit overflow; clamp instead of wrapping
  assign raw  = 19'(acc) + (prod_v ? 19'(prod) : 19'sd0);
  assign sum  = (raw[18] ^ raw[17]) ? {raw[18], {17{~raw[18]}}} : raw[17:0];
  assign r    = sum >>> OUT_SHIFT;
  assign clip = ~(&r[17:15]) & (|r[17:15]);
  assign sat  = clip ? {r[17], {15{~r[17]}}} : r[15:0];

  always_ff @(posedge i_EMUCLK)
    if (i_RST) begin
      dly               <= '0;
      prod              <= '0;
      prod_v            <= 1'b0;
      acc               <= '0;
      cnt               <= '0;
      first_frame       <= 1'b1;
      o_ACC_SIGNED      <= '0;
      o_ACC_SIGNED_STRB <= 1'b0;
      o_ACC_CLIP        <= 1'b0;
    end else if (!i_phi1_NCEN_n) begin
      dly    <= (dly << 1) | CYC_DLY'(i_CYCLE_00);
      prod   <= 14'(s) * 14'(vol);
      prod_v <= (i_DAC_EN_MO | i_DAC_EN_RO) & ~i_INHIBIT_FDBK;
      acc    <= mk ? '0 : sum;
      if (mk)
        first_frame <= 1'b0;
      if (mk && !first_frame) begin
        o_ACC_SIGNED      <= sat;
        o_ACC_CLIP        <= clip;
        o_ACC_SIGNED_STRB <= 1'b1;
        cnt               <= 4'(STRB_LEN);
      end else if (cnt != 4'd0) begin
        cnt               <= cnt - 4'd1;
        o_ACC_SIGNED_STRB <= cnt != 4'd1;
      end
    end
endmodule
